// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants, opcodes and queue entry type for the fetch/issue queue
package fetch_pkg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } queue_entry_t;

    function automatic logic is_mem_op(input logic [6:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

endpackage

// File: rtl/fetch_issue_queue_if.sv
// rtl/fetch_issue_queue_if.sv - instruction memory request/response bus
interface fetch_issue_queue_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic [63:0] imem_rdata;
    logic        imem_valid;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_valid
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_valid
    );

endinterface

// File: rtl/issue_pair_checker.sv
// rtl/issue_pair_checker.sv - decides whether two adjacent instructions may issue together
module issue_pair_checker
    import fetch_pkg::*;
(
    input  logic [31:0] ins0,
    input  logic [31:0] ins1,
    output logic        pair_ok
);

    logic [6:0] op0;
    logic [6:0] op1;
    logic [4:0] rd0;
    logic [4:0] rd1;
    logic [4:0] rs1_1;
    logic [4:0] rs2_1;
    logic       raw;
    logic       waw;
    logic       both_mem;
    logic       ctl0;
    logic       unused_fields;

    assign op0   = ins0[6:0];
    assign op1   = ins1[6:0];
    assign rd0   = ins0[11:7];
    assign rd1   = ins1[11:7];
    assign rs1_1 = ins1[19:15];
    assign rs2_1 = ins1[24:20];

    // Register fields are compared regardless of format; a false hazard only costs a cycle.
    assign raw      = (rd0 != 5'd0) && ((rs1_1 == rd0) || (rs2_1 == rd0));
    assign waw      = (rd0 != 5'd0) && (rd1 == rd0);
    assign both_mem = is_mem_op(op0) && is_mem_op(op1);
    assign ctl0     = (op0 == OP_BRANCH) || (op0 == OP_JAL) || (op0 == OP_JALR);

    assign pair_ok = !(raw || waw || both_mem || ctl0);

    assign unused_fields = ^{ins0[31:12], ins1[31:25], ins1[14:12]};

endmodule

// File: rtl/fetch_issue_queue.sv
// rtl/fetch_issue_queue.sv - fetch queue and issue stage; FETCH_DUAL_ISSUE_EN enables slot 1 and the pair checker
module fetch_issue_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    fetch_issue_queue_if.master        imem,
    input  logic                       stall,
    input  logic                       flush,
    input  logic [31:0]                flush_pc,
    output logic [31:0]                instruction0,
    output logic [31:0]                instruction1,
    output logic                       datapath_1_enable,
    output logic                       datapath_2_enable,
    output logic [31:0]                issue_pc
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef logic [AW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    queue_entry_t q_mem [DEPTH];
    ptr_t         head;
    ptr_t         tail;
    cnt_t         count;

    logic [31:0]  fetch_pc;
    logic [28:0]  req_base;
    logic         req_odd;
    logic         pending;
    logic         discard;

    logic         resp_fire;
    logic         push_fire;
    logic [1:0]   push_n;
    logic [1:0]   pop_n;
    logic         issue_one;
    logic         issue_two;
    logic         issued;
    logic         dual_ok;
    queue_entry_t head_e;

    // At most one request in flight, and only when a full pair is guaranteed to fit.
    assign imem.imem_req  = !rst && !flush && !pending && (count <= cnt_t'(DEPTH - 2));
    assign imem.imem_addr = {fetch_pc[31:3], 3'b000};

    assign resp_fire = imem.imem_valid && pending;
    assign push_fire = resp_fire && !discard && !flush;
    assign push_n    = !push_fire ? 2'd0 : (req_odd ? 2'd1 : 2'd2);
    assign head_e    = q_mem[head];
    assign issued    = issue_one || issue_two;

    // Issue selection: pair when two entries exist and the checker allows it, else head alone.
    always_comb begin
        issue_one = 1'b0;
        issue_two = 1'b0;
        pop_n     = 2'd0;
        if (!stall && !flush) begin
            if ((count >= cnt_t'(2)) && dual_ok) begin
                issue_two = 1'b1;
                pop_n     = 2'd2;
            end else if (count != '0) begin
                issue_one = 1'b1;
                pop_n     = 2'd1;
            end
        end
    end

    // Fetch address, outstanding request and stale-response tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            req_base <= '0;
            req_odd  <= 1'b0;
            pending  <= 1'b0;
            discard  <= 1'b0;
        end else if (flush) begin
            fetch_pc <= flush_pc;
            pending  <= pending && !imem.imem_valid;
            discard  <= pending && !imem.imem_valid;
        end else begin
            if (resp_fire) begin
                pending <= 1'b0;
                discard <= 1'b0;
            end
            if (imem.imem_req) begin
                pending  <= 1'b1;
                req_base <= fetch_pc[31:3];
                req_odd  <= fetch_pc[2];
                fetch_pc <= {fetch_pc[31:3] + 29'd1, 3'b000};
            end
        end
    end

    // Queue pointers and occupancy; push and pop net out in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + ptr_t'(pop_n);
            tail  <= tail + ptr_t'(push_n);
            count <= count + cnt_t'(push_n) - cnt_t'(pop_n);
        end
    end

    // Queue storage; an odd fetch target only keeps the upper word of the pair.
    always_ff @(posedge clk) begin
        if (push_fire) begin
            if (req_odd) begin
                q_mem[tail] <= '{instr: imem.imem_rdata[63:32], pc: {req_base, 3'b100}};
            end else begin
                q_mem[tail]               <= '{instr: imem.imem_rdata[31:0],  pc: {req_base, 3'b000}};
                q_mem[tail + ptr_t'(1)]   <= '{instr: imem.imem_rdata[63:32], pc: {req_base, 3'b100}};
            end
        end
    end

    // Slot 0 issue register; issue_pc follows the PC carried with the head entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            datapath_1_enable <= 1'b0;
            instruction0      <= NOP;
            issue_pc          <= RESET_PC;
        end else if (flush) begin
            datapath_1_enable <= 1'b0;
            instruction0      <= NOP;
            issue_pc          <= flush_pc;
        end else if (!stall) begin
            datapath_1_enable <= issued;
            instruction0      <= issued ? head_e.instr : NOP;
            if (issued) begin
                issue_pc <= head_e.pc;
            end
        end
    end

`ifdef FETCH_DUAL_ISSUE_EN
    logic [31:0] next_instr;
    logic        pair_ok;

    assign next_instr = q_mem[head + ptr_t'(1)].instr;

    issue_pair_checker u_pair_checker (
        .ins0    (head_e.instr),
        .ins1    (next_instr),
        .pair_ok (pair_ok)
    );

    assign dual_ok = pair_ok;

    // Slot 1 issue register.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            datapath_2_enable <= 1'b0;
            instruction1      <= NOP;
        end else if (!stall) begin
            datapath_2_enable <= issue_two;
            instruction1      <= issue_two ? next_instr : NOP;
        end
    end
`else
    assign dual_ok           = 1'b0;
    assign datapath_2_enable = 1'b0;
    assign instruction1      = NOP;
`endif

endmodule

// File: tb/tb_fetch_issue_queue.sv
// tb/tb_fetch_issue_queue.sv - directed self-checking bench for fetch_issue_queue
module tb_fetch_issue_queue;

    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_DUAL_ISSUE_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = 32'h0;
    logic [31:0] instruction0;
    logic [31:0] instruction1;
    logic        datapath_1_enable;
    logic        datapath_2_enable;
    logic [31:0] issue_pc;

    logic [31:0] mem [256];
    int          mem_lat = 1;
    int          checks = 0;
    int          errors = 0;

    fetch_issue_queue_if imem_bus ();

    fetch_issue_queue #(
        .DEPTH    (8),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .imem              (imem_bus.master),
        .stall             (stall),
        .flush             (flush),
        .flush_pc          (flush_pc),
        .instruction0      (instruction0),
        .instruction1      (instruction1),
        .datapath_1_enable (datapath_1_enable),
        .datapath_2_enable (datapath_2_enable),
        .issue_pc          (issue_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] wordof(input logic [31:0] pc);
        return {pc[13:2] + 12'd1, 20'h00013};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic fill_default();
        for (int i = 0; i < 256; i++) mem[i] = wordof(32'(i * 4));
    endtask

    task automatic restart(input int lat);
        mem_lat = lat;
        stall   = 1'b0;
        flush   = 1'b0;
        rst     = 1'b1;
        step(8);
        rst     = 1'b0;
    endtask

    // Memory model: a request seen in cycle N answers in cycle N+mem_lat.
    initial begin : responder
        int         cnt;
        logic       busy;
        logic [7:0] widx;
        cnt  = 0;
        busy = 1'b0;
        widx = 8'd0;
        imem_bus.imem_valid = 1'b0;
        imem_bus.imem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            imem_bus.imem_valid = 1'b0;
            if (busy) begin
                cnt--;
                if (cnt == 0) begin
                    busy = 1'b0;
                    imem_bus.imem_valid = 1'b1;
                    imem_bus.imem_rdata = {mem[widx + 8'd1], mem[widx]};
                end
            end
            @(negedge clk);
            if (imem_bus.imem_req === 1'b1) begin
                busy = 1'b1;
                cnt  = mem_lat;
                widx = imem_bus.imem_addr[9:2];
            end
        end
    end

    initial begin
        // Reset state and first pair with latency 1.
        fill_default();
        mem[0] = 32'h00100093;
        mem[1] = 32'h00200113;
        mem[2] = 32'h00300193;
        mem[3] = 32'h00400213;
        mem_lat = 1;
        rst = 1'b1;
        step(4);
        check("rst_en0", datapath_1_enable, 0);
        check("rst_en1", datapath_2_enable, 0);
        check("rst_ins0", instruction0, NOP);
        check("rst_ins1", instruction1, NOP);
        check("rst_pc", issue_pc, 32'h0);
        check("rst_req", imem_bus.imem_req, 0);
        rst = 1'b0;
        #1;
        check("first_req", imem_bus.imem_req, 1);
        check("first_addr", imem_bus.imem_addr, 32'h0);
        step(2);
        check("second_req", imem_bus.imem_req, 1);
        check("second_addr", imem_bus.imem_addr, 32'h8);
        step(1);
        check("p1_en0", datapath_1_enable, 1);
        check("p1_en1", datapath_2_enable, DUAL);
        check("p1_ins0", instruction0, 32'h00100093);
        check("p1_ins1", instruction1, DUAL ? 32'h00200113 : NOP);
        check("p1_pc", issue_pc, 32'h0);
        step(1);
        check("p1b_en0", datapath_1_enable, !DUAL);
        check("p1b_ins0", instruction0, DUAL ? NOP : 32'h00200113);
        step(1);
        check("p2_en0", datapath_1_enable, 1);
        check("p2_ins0", instruction0, 32'h00300193);
        check("p2_ins1", instruction1, DUAL ? 32'h00400213 : NOP);
        check("p2_pc", issue_pc, 32'h8);

        // RAW pair issues split.
        fill_default();
        mem[0] = 32'h00100093;
        mem[1] = 32'h001081B3;
        restart(1);
        step(3);
        check("raw_en0", datapath_1_enable, 1);
        check("raw_en1", datapath_2_enable, 0);
        check("raw_ins0", instruction0, 32'h00100093);
        check("raw_ins1", instruction1, NOP);
        check("raw_pc", issue_pc, 32'h0);
        step(1);
        check("raw2_ins0", instruction0, 32'h001081B3);
        check("raw2_pc", issue_pc, 32'h4);
        check("raw2_en1", datapath_2_enable, 0);

        // Branch, load/store and WAW pairs split; an independent pair follows.
        fill_default();
        mem[0] = 32'h00208463;
        mem[1] = 32'h00500293;
        mem[2] = 32'h00002303;
        mem[3] = 32'h00002023;
        mem[4] = 32'h00100393;
        mem[5] = 32'h00200393;
        mem[6] = 32'h00100413;
        mem[7] = 32'h00200493;
        restart(1);
        step(3);
        check("beq_ins0", instruction0, 32'h00208463);
        check("beq_en1", datapath_2_enable, 0);
        step(1);
        check("beq_next_ins0", instruction0, 32'h00500293);
        check("beq_next_pc", issue_pc, 32'h4);
        step(1);
        check("ld_ins0", instruction0, 32'h00002303);
        check("ld_en1", datapath_2_enable, 0);
        step(1);
        check("st_ins0", instruction0, 32'h00002023);
        check("st_pc", issue_pc, 32'hC);
        step(1);
        check("waw_ins0", instruction0, 32'h00100393);
        check("waw_en1", datapath_2_enable, 0);
        step(1);
        check("waw_next_ins0", instruction0, 32'h00200393);
        check("waw_next_pc", issue_pc, 32'h14);
        step(1);
        check("indep_ins0", instruction0, 32'h00100413);
        check("indep_pc", issue_pc, 32'h18);
        check("indep_en1", datapath_2_enable, DUAL);
        check("indep_ins1", instruction1, DUAL ? 32'h00200493 : NOP);

        // Stall until the queue is full, then drain in order.
        fill_default();
        restart(1);
        step(3);
        check("pre_stall_ins0", instruction0, wordof(32'h0));
        stall = 1'b1;
        step(7);
        for (int k = 0; k < 3; k++) begin
            step(1);
            check("full_req", imem_bus.imem_req, 0);
            check("stall_en0", datapath_1_enable, 1);
            check("stall_ins0", instruction0, wordof(32'h0));
            check("stall_ins1", instruction1, DUAL ? wordof(32'h4) : NOP);
            check("stall_pc", issue_pc, 32'h0);
        end
        stall = 1'b0;
        for (int k = 0; k < 4; k++) begin
            logic [31:0] exp_pc;
            step(1);
            exp_pc = DUAL ? 32'((k + 1) * 8) : 32'((k + 1) * 4);
            check("drain_pc", issue_pc, exp_pc);
            check("drain_ins0", instruction0, wordof(exp_pc));
            check("drain_en1", datapath_2_enable, DUAL);
        end

        // Flush to an odd target while a slow fetch is outstanding.
        fill_default();
        restart(3);
        step(1);
        flush    = 1'b1;
        flush_pc = 32'h104;
        #1;
        check("flush_req", imem_bus.imem_req, 0);
        step(1);
        flush = 1'b0;
        check("flush_en0", datapath_1_enable, 0);
        check("flush_en1", datapath_2_enable, 0);
        check("flush_ins0", instruction0, NOP);
        check("flush_ins1", instruction1, NOP);
        check("flush_pc_out", issue_pc, 32'h104);
        #1;
        check("pending_req", imem_bus.imem_req, 0);
        step(2);
        check("redir_req", imem_bus.imem_req, 1);
        check("redir_addr", imem_bus.imem_addr, 32'h100);
        step(1);
        check("late_dropped", datapath_1_enable, 0);
        step(4);
        check("odd_en0", datapath_1_enable, 1);
        check("odd_en1", datapath_2_enable, 0);
        check("odd_ins0", instruction0, wordof(32'h104));
        check("odd_pc", issue_pc, 32'h104);
        step(1);
        check("odd_single", datapath_1_enable, 0);

        // Flush coinciding with the response.
        fill_default();
        restart(1);
        step(1);
        flush    = 1'b1;
        flush_pc = 32'h40;
        step(1);
        flush = 1'b0;
        #1;
        check("same_req", imem_bus.imem_req, 1);
        check("same_addr", imem_bus.imem_addr, 32'h40);
        step(1);
        check("same_empty0", datapath_1_enable, 0);
        step(1);
        check("same_empty1", datapath_1_enable, 0);
        step(1);
        check("same_en0", datapath_1_enable, 1);
        check("same_ins0", instruction0, wordof(32'h40));
        check("same_pc", issue_pc, 32'h40);
        check("same_en1", datapath_2_enable, DUAL);
        check("same_ins1", instruction1, DUAL ? wordof(32'h44) : NOP);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_issue_queue.md
# fetch_issue_queue

Front-end stage directly upstream of the dual-issue `datapath`. It fetches 64-bit instruction pairs from instruction memory and buffers individual 32-bit words in a circular queue. Each cycle it issues zero, one or two instructions as `instruction0`/`instruction1` with per-slot enables. A built-in pair checker holds back slot 1 whenever the two instructions cannot execute together.

## Interface
- `DEPTH`, 8: queue entries (32-bit words); power of two, ≥ 4
- `RESET_PC`, 32'h0000_0000: fetch address after reset
- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset; one clock; reset is synchronous and active-high
- `imem_req`  out  1  fetch request for the pair at `imem_addr`
- `imem_addr`  out  32  8-byte-aligned fetch address
- `imem_rdata`  in  64  `[31:0]` = word at addr, `[63:32]` = word at addr+4
- `imem_valid`  in  1  response valid; arrives ≥ 1 cycle after the accepted request
- `stall`  in  1  datapath cannot accept; hold issue outputs
- `flush`  in  1  redirect; discard queue and in-flight fetch
- `flush_pc`  in  32  redirect target, word aligned
- `instruction0`, `instruction1`  out  32  issued instructions; NOP `32'h0000_0013` when the slot is disabled
- `datapath_1_enable`, `datapath_2_enable`  out  1  slot valid
- `issue_pc`  out  32  PC of `instruction0`

## Operation
- State: `fetch_pc`, queue (head, tail, `count`), `pending` (one outstanding request max), `discard`, registered issue outputs.
- Request rule: `imem_req` = !rst & !flush & !pending & (`count` ≤ DEPTH−2). The request is accepted in the same cycle. On acceptance, set `pending` and `fetch_pc` ← `{fetch_pc[31:3]+1, 3'b0}`.
- Response: `imem_valid` & `pending` & !`discard` pushes words. Both words are pushed if the request PC had bit 2 = 0; only `[63:32]` is pushed if bit 2 = 1 (post-flush odd target). Either case clears `pending`.
  - If `discard` is set, the response is dropped and both `pending` and `discard` are cleared.
  - `imem_valid` without `pending` is ignored.
- Issue, when !stall and !flush:
  - `count` = 0: both enables 0, both slots NOP.
  - `count` = 1: issue the head in slot 0 only.
  - `count` ≥ 2: issue both unless the pair checker objects, in which case issue the head in slot 0 only.
  - The checker objects if any of these hold:
    - ins1 rs1 or rs2 equals ins0 rd, with rd ≠ 0 (RAW);
    - both are load/store (opcodes 0000011/0100011);
    - ins0 is a branch or jump (1100011, 1101111, 1100111);
    - ins1 rd equals ins0 rd, with rd ≠ 0 (WAW).
- Push and pop occur in the same cycle; `count` updates by net (+pushed − popped).
- `stall`: issue outputs and the queue head are held. Fetch continues subject to the request rule.
- `flush` (priority over stall and push):
  - next cycle: `count` = 0, both enables 0, outputs NOP;
  - `fetch_pc` ← `flush_pc`, with the request address aligned down to 8;
  - `discard` ← `pending` & !`imem_valid`.
  - A request may be issued in the cycle after a flush.
- Reset values: `fetch_pc` = RESET_PC, `count` = 0, `pending` = `discard` = 0, `imem_req` = 0, enables 0, instructions NOP, `issue_pc` = RESET_PC.

## Timing
- Issue outputs are registered. A word pushed at edge N is issuable at edge N+1 at the earliest.
- Memory latency is unbounded. Throughput is 2 words per (latency+1) cycles, because only one request is outstanding.
- `issue_pc` increments by 4 per issued instruction, or by 8 when both slots issue. On flush it loads `flush_pc`, tracked with each queue entry.
- `rst` asserted mid-fetch: any outstanding response is never consumed, because `pending` = 0 causes it to be ignored.

## Configuration
- `FETCH_DUAL_ISSUE_EN` defined: behaviour as above.
- Undefined: `datapath_2_enable` is tied 0 and `instruction1` tied NOP. At most one instruction issues per cycle, and the pair checker is not instantiated.

## Structure
- Package `fetch_pkg`: NOP constant, opcode constants (LOAD, STORE, BRANCH, JAL, JALR), and a `queue_entry_t` struct {instr[31:0], pc[31:0]}.
- One sub-module: `issue_pair_checker` (combinational; inputs ins0, ins1; output `pair_ok`).

## Test plan
- Reset, memory returns `addi x1,x0,1` / `addi x2,x0,2` with latency 1 → both enables 1 with that pair; `issue_pc` = 0, then 8.
- Pair `addi x1,x0,1` / `add x3,x1,x1` → cycle 1 issues slot 0 only, enable2 = 0, NOP in slot 1; next issue has `add` in slot 0, `issue_pc` = 4.
- `stall` held 3 cycles with a full queue → outputs unchanged; `imem_req` = 0 while `count` > DEPTH−2; no overflow.
- Flush to `0x104` while a request is pending → late response dropped; next request at `0x100`; only `imem_rdata[63:32]` is queued; `issue_pc` = `0x104`.
- `beq` followed by `addi` → `beq` issued alone.
- `flush` and `imem_valid` in the same cycle → response dropped, `count` = 0, `discard` = 0.
